// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type, kernel/output sizing functions and weight vector type.
package conv_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, SWAP = 2'd3} state_t;
   localparam int DefKernelWidth = 3;
   localparam int DefWeightWidth = 2;
   function automatic int kernel_area(input int kernel_width);
      return kernel_width * kernel_width;
   endfunction
   function automatic int out_count(input int line_width, input int line_count, input int kernel_width);
      return (line_width - kernel_width + 1) * (line_count - kernel_width + 1);
   endfunction
   typedef logic [kernel_area(DefKernelWidth)*DefWeightWidth-1:0] weight_vec_t;
endpackage

// File: rtl/conv_weight_bank.sv
// conv_weight_bank: shadow/active weight registers with an armed flag; the active bank
// is loaded from the shadow bank only on swap.
module conv_weight_bank #(
   parameter int KernelArea = 9,
   parameter int WeightWidth = 2,
   parameter int IdxWidth = 4
)(
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            cfg_valid_i,
   output logic                            cfg_ready_o,
   input  logic [IdxWidth-1:0]             cfg_idx_i,
   input  logic [WeightWidth-1:0]          cfg_weight_i,
   input  logic                            cfg_last_i,
   input  logic                            swap_i,
   output logic                            armed_o,
   output logic [KernelArea*WeightWidth-1:0] weights_o
);
   logic [KernelArea*WeightWidth-1:0] shadow;
   logic fire;
   assign cfg_ready_o = ~armed_o;
   assign fire = cfg_valid_i && cfg_ready_o;
   // Out-of-range indices match no slot and are silently dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow <= '0;
         weights_o <= '0;
         armed_o <= 1'b0;
      end else begin
         for (int i = 0; i < KernelArea; i++)
            if (fire && cfg_idx_i == IdxWidth'(i)) shadow[i*WeightWidth +: WeightWidth] <= cfg_weight_i;
         if (swap_i) weights_o <= shadow;
         armed_o <= swap_i ? 1'b0 : (armed_o || (fire && cfg_last_i));
      end
   end
endmodule

// File: rtl/conv_frame_seq.sv
// conv_frame_seq: frame sequencer gating a pixel stream into a convolution engine and
// swapping kernel weights only between frames. CONV_SEQ_STATS_EN adds frame statistics.
module conv_frame_seq
   import conv_pkg::*;
#(
   parameter int LineWidthPx = 160,
   parameter int LineCountPx = 120,
   parameter int KernelWidth = 3,
   parameter int WeightWidth = 2,
   parameter int WidthIn = 1,
   localparam int KernelArea = kernel_area(KernelWidth),
   localparam int IdxWidth = KernelArea > 1 ? $clog2(KernelArea) : 1
)(
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              cfg_valid_i,
   output logic                              cfg_ready_o,
   input  logic [IdxWidth-1:0]               cfg_idx_i,
   input  logic [WeightWidth-1:0]            cfg_weight_i,
   input  logic                              cfg_last_i,
   input  logic                              pix_valid_i,
   output logic                              pix_ready_o,
   input  logic [WidthIn-1:0]                pix_data_i,
   output logic                              conv_valid_o,
   input  logic                              conv_ready_i,
   output logic [WidthIn-1:0]                conv_data_o,
   input  logic                              conv_out_fire_i,
   output logic [KernelArea*WeightWidth-1:0] weights_o,
   output logic                              frame_done_o,
`ifdef CONV_SEQ_STATS_EN
   output logic [15:0]                       frame_count_o,
   output logic [15:0]                       drain_cycles_o,
`endif
   output logic [1:0]                        state_o
);
   localparam int InTotal = LineWidthPx * LineCountPx;
   localparam int OutTotal = out_count(LineWidthPx, LineCountPx, KernelWidth);
   localparam int InW = $clog2(InTotal + 1);
   localparam int OutW = OutTotal > 0 ? $clog2(OutTotal + 1) : 1;
   state_t state, state_nxt;
   logic armed, pix_fire, in_last, out_fire, frame_done;
   logic [InW-1:0] in_cnt;
   logic [OutW-1:0] out_cnt, out_cnt_inc;
   assign pix_fire = state == RUN && pix_valid_i && conv_ready_i;
   assign in_last = pix_fire && in_cnt == InW'(InTotal - 1);
   assign out_fire = conv_out_fire_i && (state == RUN || state == DRAIN);
   assign out_cnt_inc = out_cnt + OutW'(out_fire);
   assign frame_done = state == DRAIN && out_cnt_inc == OutW'(OutTotal);
   conv_weight_bank #(
      .KernelArea(KernelArea),
      .WeightWidth(WeightWidth),
      .IdxWidth(IdxWidth)
   ) u_bank (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .cfg_valid_i(cfg_valid_i),
      .cfg_ready_o(cfg_ready_o),
      .cfg_idx_i(cfg_idx_i),
      .cfg_weight_i(cfg_weight_i),
      .cfg_last_i(cfg_last_i),
      .swap_i(state == SWAP),
      .armed_o(armed),
      .weights_o(weights_o)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else state <= state_nxt;
   end
   // The registered armed flag decides at the frame boundary, so a set completing
   // in the same cycle waits for the next boundary.
   always_comb begin
      state_nxt = state == IDLE ? (armed ? SWAP : IDLE) :
                  state == SWAP ? RUN :
                  state == RUN ? (in_last ? DRAIN : RUN) :
                  frame_done ? (armed ? SWAP : RUN) : DRAIN;
   end
   always_comb begin
      pix_ready_o = state == RUN && conv_ready_i;
      conv_valid_o = state == RUN && pix_valid_i;
      conv_data_o = pix_data_i;
      frame_done_o = frame_done;
      state_o = state;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         in_cnt <= '0;
         out_cnt <= '0;
      end else begin
         in_cnt <= in_last ? '0 : in_cnt + InW'(pix_fire);
         out_cnt <= frame_done ? '0 : out_cnt_inc;
      end
   end
`ifdef CONV_SEQ_STATS_EN
   logic [15:0] drain_cnt, drain_cnt_nxt;
   assign drain_cnt_nxt = &drain_cnt ? drain_cnt : drain_cnt + 16'd1;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_count_o <= '0;
         drain_cycles_o <= '0;
         drain_cnt <= '0;
      end else begin
         if (frame_done) begin
            frame_count_o <= frame_count_o + 16'd1;
            drain_cycles_o <= drain_cnt_nxt;
         end
         drain_cnt <= frame_done ? '0 : state == DRAIN ? drain_cnt_nxt : drain_cnt;
      end
   end
`endif
endmodule

// File: tb/tb_conv_frame_seq.sv
// tb_conv_frame_seq: directed bench for conv_frame_seq on a 5x4 frame with a 3x3 kernel.
module tb_conv_frame_seq;
   logic clk = 1'b0, rst = 1'b1;
   logic cfg_valid = 1'b0, cfg_last = 1'b0, cfg_ready;
   logic [3:0] cfg_idx = '0;
   logic [1:0] cfg_weight = '0;
   logic pix_valid = 1'b0, pix_ready, pix_data = 1'b0;
   logic conv_valid, conv_ready = 1'b0, conv_data, conv_out_fire = 1'b0;
   logic [17:0] weights;
   logic frame_done;
   logic [1:0] state;
`ifdef CONV_SEQ_STATS_EN
   logic [15:0] frame_count, drain_cycles;
`endif
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   conv_frame_seq #(
      .LineWidthPx(5), .LineCountPx(4), .KernelWidth(3), .WeightWidth(2), .WidthIn(1)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_idx_i(cfg_idx),
      .cfg_weight_i(cfg_weight), .cfg_last_i(cfg_last),
      .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix_data),
      .conv_valid_o(conv_valid), .conv_ready_i(conv_ready), .conv_data_o(conv_data),
      .conv_out_fire_i(conv_out_fire), .weights_o(weights), .frame_done_o(frame_done),
`ifdef CONV_SEQ_STATS_EN
      .frame_count_o(frame_count), .drain_cycles_o(drain_cycles),
`endif
      .state_o(state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int idx, input logic [1:0] w, input logic last);
      cfg_valid = 1'b1; cfg_idx = 4'(idx); cfg_weight = w; cfg_last = last;
      tick();
      cfg_valid = 1'b0; cfg_last = 1'b0;
   endtask

   task automatic pix_burst(input int n);
      for (int i = 0; i < n; i++) begin
         pix_valid = 1'b1; conv_ready = 1'b1; pix_data = i[0];
         #1;
         check("run_pix_ready", pix_ready, 1);
         check("run_conv_data", conv_data, i[0]);
         tick();
      end
      pix_valid = 1'b0;
   endtask

   task automatic out_fires(input int n, input logic last_done);
      for (int i = 0; i < n; i++) begin
         conv_out_fire = 1'b1;
         #1;
         check("frame_done", frame_done, last_done && i == n - 1);
         tick();
      end
      conv_out_fire = 1'b0;
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      check("rst_state", state, 0);
      check("rst_weights", weights, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_frame_done", frame_done, 0);
      // Idle with upstream offering data and engine pulses: nothing moves or counts.
      pix_valid = 1'b1; conv_ready = 1'b1; conv_out_fire = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("idle_state", state, 0);
      check("idle_pix_ready", pix_ready, 0);
      check("idle_conv_valid", conv_valid, 0);
      pix_valid = 1'b0; conv_out_fire = 1'b0;
      cfg_write(9, 2'b11, 1'b0);
      for (int i = 0; i < 9; i++) cfg_write(i, 2'b01, i == 8);
      check("armed_cfg_ready", cfg_ready, 0);
      check("armed_state", state, 0);
      tick();
      check("swap_state", state, 3);
      check("swap_weights_old", weights, 0);
      tick();
      check("run_state", state, 1);
      check("run_weights", weights, 32'h15555);
      check("run_cfg_ready", cfg_ready, 1);
      // Frame 1: two engine outputs during RUN, new set of -1 mid-frame.
      pix_burst(10);
      out_fires(2, 1'b0);
      for (int i = 0; i < 9; i++) cfg_write(i, 2'b11, i == 8);
      check("mid_cfg_ready", cfg_ready, 0);
      check("mid_weights", weights, 32'h15555);
      conv_ready = 1'b0; pix_valid = 1'b1;
      #1;
      check("stall_pix_ready", pix_ready, 0);
      check("stall_conv_valid", conv_valid, 1);
      tick();
      pix_burst(9);
      check("pre_drain_state", state, 1);
      pix_burst(1);
      check("drain_state", state, 2);
      pix_valid = 1'b1;
      #1;
      check("drain_pix_ready", pix_ready, 0);
      check("drain_conv_valid", conv_valid, 0);
      pix_valid = 1'b0;
      out_fires(4, 1'b1);
      check("f1_swap_state", state, 3);
      check("f1_swap_weights", weights, 32'h15555);
      tick();
      check("f1_run_state", state, 1);
      check("f1_new_weights", weights, 32'h3FFFF);
      // Frame 2: set completes in the same cycle as the last output.
      pix_burst(20);
      for (int i = 0; i < 8; i++) cfg_write(i, 2'b10, 1'b0);
      out_fires(5, 1'b0);
      cfg_valid = 1'b1; cfg_idx = 4'd8; cfg_weight = 2'b10; cfg_last = 1'b1; conv_out_fire = 1'b1;
      #1;
      check("f2_done", frame_done, 1);
      tick();
      cfg_valid = 1'b0; cfg_last = 1'b0; conv_out_fire = 1'b0;
      check("f2_state", state, 1);
      check("f2_weights_kept", weights, 32'h3FFFF);
      check("f2_cfg_ready", cfg_ready, 0);
      // Frame 3 runs with the old weights, swap at its end.
      pix_burst(20);
      check("f3_weights", weights, 32'h3FFFF);
      out_fires(6, 1'b1);
      check("f3_swap_state", state, 3);
      tick();
      check("f3_run_state", state, 1);
      check("f3_new_weights", weights, 32'h2AAAA);
`ifdef CONV_SEQ_STATS_EN
      check("frame_count", frame_count, 3);
`endif
      // Frame 4 aborted by reset after 10 pixels, with a set armed.
      pix_burst(10);
      for (int i = 0; i < 9; i++) cfg_write(i, 2'b01, i == 8);
      rst = 1'b1; pix_valid = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_state", state, 0);
      check("abort_pix_ready", pix_ready, 0);
      check("abort_conv_valid", conv_valid, 0);
      check("abort_weights", weights, 0);
      check("abort_frame_done", frame_done, 0);
      check("abort_cfg_ready", cfg_ready, 1);
`ifdef CONV_SEQ_STATS_EN
      check("abort_frame_count", frame_count, 0);
`endif
      tick(); tick();
      check("abort_stays_idle", state, 0);
      pix_valid = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/conv_frame_seq.md
CONV_FRAME_SEQ -- requirements
Module: conv_frame_seq

Interface
REQ-001 SHALL have parameter LineWidthPx, default 160: pixels per line.
REQ-002 SHALL have parameter LineCountPx, default 120: lines per frame.
REQ-003 SHALL have parameter KernelWidth, default 3: kernel side; KernelArea = KernelWidth*KernelWidth.
REQ-004 SHALL have parameter WeightWidth, default 2: signed weight width.
REQ-005 SHALL have parameter WidthIn, default 1: pixel width.
REQ-006 SHALL have port clk_i, input, 1: the single clock.
REQ-007 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have ports cfg_valid_i in 1, cfg_ready_o out 1, cfg_idx_i in $clog2(KernelArea), cfg_weight_i in WeightWidth, cfg_last_i in 1: weight-write channel; cfg_last_i marks the final write of a set.
REQ-009 SHALL have ports pix_valid_i in 1, pix_ready_o out 1, pix_data_i in WidthIn: upstream pixel stream.
REQ-010 SHALL have ports conv_valid_o out 1, conv_ready_i in 1, conv_data_o out WidthIn: stream to the convolution engine.
REQ-011 SHALL have port conv_out_fire_i, input, 1: the engine's valid_o & ready_i.
REQ-012 SHALL have port weights_o, output, KernelArea*WeightWidth: packed active weights, row-major, index 0 in the LSBs.
REQ-013 SHALL have ports frame_done_o out 1, a one-cycle pulse, and state_o out 2: current FSM state.

Function
REQ-014 SHALL hold a shadow bank and an active bank; a cfg fire writes shadow[cfg_idx_i]; cfg_idx_i >= KernelArea is accepted and dropped.
REQ-015 SHALL set armed on a cfg fire with cfg_last_i=1; cfg_ready_o SHALL equal ~armed.
REQ-016 SHALL implement states IDLE=0, RUN=1, DRAIN=2, SWAP=3.
REQ-017 IDLE: pix_ready_o=0, conv_valid_o=0; SHALL go to SWAP when armed.
REQ-018 SWAP: lasts one cycle; active<=shadow and armed<=0; weights_o SHALL show new values the cycle after SWAP; next state RUN.
REQ-019 RUN: pix_ready_o=conv_ready_i, conv_valid_o=pix_valid_i, conv_data_o=pix_data_i, all combinational; each fire SHALL increment in_cnt.
REQ-020 RUN: the fire that makes in_cnt = LineWidthPx*LineCountPx SHALL move the FSM to DRAIN and clear in_cnt.
REQ-021 DRAIN: pix_ready_o=0, conv_valid_o=0; weights_o SHALL stay stable.
REQ-022 SHALL count conv_out_fire_i in out_cnt during RUN and DRAIN, and ignore it in IDLE and SWAP.
REQ-023 When out_cnt reaches (LineWidthPx-KernelWidth+1)*(LineCountPx-KernelWidth+1) in DRAIN, SHALL pulse frame_done_o in that cycle and clear out_cnt; next state SWAP if armed, else RUN.
REQ-024 Arming uses the registered armed flag: a cfg_last fire in the same cycle as DRAIN completion SHALL go to RUN, with the swap taken at the next frame boundary.
REQ-025 Weights SHALL never change while a frame is in flight.

Reset
REQ-026 On rst_i: state IDLE, in_cnt=0, out_cnt=0, armed=0, both banks 0, weights_o=0, frame_done_o=0, conv_valid_o=0, pix_ready_o=0; cfg_ready_o=1 the following cycle.
REQ-027 Reset mid-frame SHALL discard any partial frame and any armed set; the engine shares rst_i.

Configuration
REQ-028 Macro CONV_SEQ_STATS_EN defined: SHALL add frame_count_o (16 b, wrapping, +1 per frame_done_o) and drain_cycles_o (16 b, saturating, DRAIN cycle count of the last frame, latched at frame_done_o); both reset to 0.
REQ-029 Macro CONV_SEQ_STATS_EN undefined: those ports and their counters SHALL not exist; all other behaviour is identical.

Structure
REQ-030 Package conv_pkg SHALL hold the state enum type, the KernelArea and out-count constant functions, and the weight-vector typedef.
REQ-031 Submodule conv_weight_bank SHALL hold the shadow/active registers, the armed flag and the swap; the FSM and counters stay in conv_frame_seq.

Verification (LineWidthPx=5, LineCountPx=4, KernelWidth=3: 20 pixels in, 6 outputs per frame)
REQ-032 Reset, no cfg -> state_o=0, pix_ready_o=0 indefinitely; 9 writes of weight 1 with cfg_last on idx 8 -> SWAP one cycle, weights_o all 1, state_o=1.
REQ-033 20 pixel fires -> state_o=2 after the 20th, pix_ready_o=0; 6 conv_out_fire_i pulses -> frame_done_o on the 6th, state_o=1.
REQ-034 New set (all -1) written mid-frame -> cfg_ready_o=0 after the last write; weights_o stays 1 until after frame end, then becomes -1.
REQ-035 cfg_last fire in the same cycle as the 6th out fire -> RUN, old weights persist one more frame, swap at the next frame end.
REQ-036 rst_i asserted after 10 pixels -> all outputs at reset values the next cycle, state_o=0; with CONV_SEQ_STATS_EN, frame_count_o=0.
